// File: rtl/sram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl_if
// Description : Bus bundle for the SRAM burst controller: command channel,
//               write/read beat streams, status and the SRAM command side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_burst_ctrl_if #(
    parameter int BYTES = 4,
    parameter int DEPTH = 1024
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = BYTES * 8;

    // Command channel
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [7:0]       req_len;
    logic [BYTES-1:0] req_byte_en;

    // Write beat stream
    logic             wdata_valid;
    logic             wdata_ready;
    logic [DW-1:0]    wdata;

    // Read beat stream
    logic             rdata_valid;
    logic             rdata_ready;
    logic [DW-1:0]    rdata;
    logic             rdata_last;

    // Status
    logic             busy;

    // SRAM command side
    logic             mem_wr_en;
    logic             mem_rd_en;
    logic [AW-1:0]    mem_address;
    logic [DW-1:0]    mem_data_in;
    logic [BYTES-1:0] mem_byte_en;
    logic [DW-1:0]    mem_data_out;

    // Controller side
    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_byte_en,
        input  wdata_valid, wdata, rdata_ready, mem_data_out,
        output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy,
        output mem_wr_en, mem_rd_en, mem_address, mem_data_in, mem_byte_en
    );

    // Client / SRAM side
    modport master (
        output req_valid, req_write, req_addr, req_len, req_byte_en,
        output wdata_valid, wdata, rdata_ready, mem_data_out,
        input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy,
        input  mem_wr_en, mem_rd_en, mem_address, mem_data_in, mem_byte_en
    );
endinterface
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_burst_ctrl
// Description : Burst controller for a single-port synchronous SRAM. Write
//               beats pass straight through to the SRAM; read beats return
//               through a 2-entry fall-through response FIFO so that a
//               stalled consumer never loses data.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_burst_ctrl #(
    parameter int BYTES = 4,
    parameter int DEPTH = 1024
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    sram_burst_ctrl_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = BYTES * 8;
    localparam logic [AW-1:0] C_ADDR_MAX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [AW-1:0]    r_addr;
    logic [7:0]       r_len;
    logic [7:0]       r_beat;
    logic [BYTES-1:0] r_be;
    logic             r_inflight;
    logic             r_inflight_last;

    logic [DW-1:0]    r_fifo_data [2];
    logic [1:0]       r_fifo_last;
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic             w_req_fire;
    logic             w_wr_fire;
    logic             w_rd_fire;
    logic             w_beat_done;
    logic [AW-1:0]    w_addr_next;
    logic             w_fifo_empty;
    logic             w_head_valid;
    logic [DW-1:0]    w_head_data;
    logic             w_head_last;
    logic             w_pop;
    logic             w_push;
    logic             w_spop;
    logic             w_req_ready;
    logic             w_wdata_ready;

    assign w_beat_done  = (r_beat == r_len);
    assign w_addr_next  = (r_addr == C_ADDR_MAX) ? '0 : r_addr + AW'(1);
    assign w_fifo_empty = (r_count == 2'd0);

    // The word returning from the SRAM is the FIFO head whenever storage is
    // empty, which gives the 2-cycle first-beat latency and lets a ready
    // consumer take it without it ever occupying a slot.
    assign w_head_valid = !w_fifo_empty || r_inflight;
    assign w_head_data  = !w_fifo_empty ? r_fifo_data[r_rptr] : bus.mem_data_out;
    assign w_head_last  = !w_fifo_empty ? r_fifo_last[r_rptr] : r_inflight_last;
    assign w_pop        = w_head_valid && bus.rdata_ready;
    assign w_push       = r_inflight && !(w_fifo_empty && bus.rdata_ready);
    assign w_spop       = w_pop && !w_fifo_empty;

    // Next-state and handshake/command decode
    always_comb begin
        w_next        = r_state;
        w_req_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        w_wr_fire     = 1'b0;
        w_rd_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = rst_n;
                if (bus.req_valid && rst_n) begin
                    w_next = bus.req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                w_wdata_ready = 1'b1;
                w_wr_fire     = bus.wdata_valid;
                if (bus.wdata_valid && w_beat_done) begin
                    w_next = S_IDLE;
                end
            end
            S_READ: begin
                // Never more than two beats owed to the consumer.
                w_rd_fire = ((r_count + {1'b0, r_inflight}) < 2'd2);
                if (w_rd_fire && w_beat_done) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_fifo_empty && !r_inflight) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_req_fire = bus.req_valid && w_req_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Burst context: latch command, advance address/beat per issued beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_len  <= '0;
            r_beat <= '0;
            r_be   <= '0;
        end else if (w_req_fire) begin
            r_addr <= bus.req_addr;
            r_len  <= bus.req_len;
            r_beat <= '0;
            r_be   <= bus.req_byte_en;
        end else if (w_wr_fire || w_rd_fire) begin
            r_addr <= w_addr_next;
            r_beat <= r_beat + 8'd1;
        end
    end

    // Track the single outstanding SRAM read and whether it is the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_rd_fire;
            r_inflight_last <= w_rd_fire && w_beat_done;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_fifo_last <= 2'b00;
        end else begin
            if (w_push) begin
                r_fifo_last[r_wptr] <= r_inflight_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_spop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_spop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Response FIFO data storage (contents qualified by occupancy)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= bus.mem_data_out;
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.wdata_ready = w_wdata_ready;
    assign bus.rdata_valid = w_head_valid;
    assign bus.rdata       = w_head_data;
    assign bus.rdata_last  = w_head_valid && w_head_last;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.mem_wr_en   = w_wr_fire;
    assign bus.mem_rd_en   = w_rd_fire;
    assign bus.mem_address = r_addr;
    assign bus.mem_data_in = bus.wdata;
    assign bus.mem_byte_en = r_be;

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_burst_ctrl
// Description : Self-checking bench for sram_burst_ctrl with a behavioural
//               SRAM, a reference memory and write/read scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_burst_ctrl;
    localparam int BYTES = 4;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    be;
    } wexp_t;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } rexp_t;

    logic clk;
    logic rst_n;

    sram_burst_ctrl_if #(.BYTES(BYTES), .DEPTH(DEPTH)) bus ();

    sram_burst_ctrl #(.BYTES(BYTES), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          pop_cnt  = 0;
    int          wr_cnt   = 0;
    int          outstanding = 0;
    wexp_t       wq [$];
    rexp_t       rq [$];
    logic [AW-1:0] ra [$];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] sram    [0:DEPTH-1];
    wexp_t       mon_w;
    rexp_t       mon_r;
    logic [AW-1:0] mon_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural synchronous SRAM: one-cycle read latency, byte-lane writes
    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.mem_byte_en[b]) sram[bus.mem_address][b*8 +: 8] <= bus.mem_data_in[b*8 +: 8];
            end
        end
        if (bus.mem_rd_en) bus.mem_data_out <= sram[bus.mem_address];
    end

    // Monitor: compare SRAM commands and read beats against the scoreboards
    always @(negedge clk) begin
        if (!rst_n) begin
            wq.delete();
            rq.delete();
            ra.delete();
            outstanding = 0;
        end else begin
            if (!bus.busy) check("idle_no_mem", {bus.mem_wr_en, bus.mem_rd_en}, 0);
            if (bus.mem_wr_en || bus.mem_rd_en) check("wr_rd_excl", bus.mem_wr_en & bus.mem_rd_en, 0);
            if (bus.mem_wr_en) begin
                wr_cnt++;
                if (wq.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    mon_w = wq.pop_front();
                    check("wr_addr", bus.mem_address, mon_w.a);
                    check("wr_data", bus.mem_data_in, mon_w.d);
                    check("wr_be", bus.mem_byte_en, mon_w.be);
                end
            end
            if (bus.mem_rd_en) begin
                check("rd_outstanding_lt2", outstanding < 2, 1);
                if (ra.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    mon_a = ra.pop_front();
                    check("rd_addr", bus.mem_address, mon_a);
                end
            end
            if (bus.rdata_valid && bus.rdata_ready) begin
                pop_cnt++;
                if (rq.size() == 0) check("rdata_unexpected", 1, 0);
                else begin
                    mon_r = rq.pop_front();
                    check("rdata", bus.rdata, mon_r.d);
                    check("rdata_last", bus.rdata_last, mon_r.last);
                end
            end
            outstanding = outstanding + (bus.mem_rd_en ? 1 : 0)
                        - ((bus.rdata_valid && bus.rdata_ready) ? 1 : 0);
        end
    end

    task automatic cmd(input logic wr, input logic [AW-1:0] a, input logic [7:0] len, input logic [3:0] be);
        int n = 0;
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_addr    = a;
        bus.req_len     = len;
        bus.req_byte_en = be;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a0, input logic [7:0] len, input logic [3:0] be,
                            input logic [31:0] d0, input logic [31:0] step);
        logic [AW-1:0] a = a0;
        logic [31:0]   d;
        int            wr_base = wr_cnt;
        cmd(1'b1, a0, len, be);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            d = d0 + step * i;
            wq.push_back('{a: a, d: d, be: be});
            for (int b = 0; b < BYTES; b++) if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
            a = (int'(a) == DEPTH - 1) ? '0 : a + 1'b1;
            bus.wdata_valid = 1'b1;
            bus.wdata       = d;
            while (!bus.wdata_ready && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("wdata_ready", bus.wdata_ready, 1);
            @(posedge clk); #1;
        end
        bus.wdata_valid = 1'b0;
        check("wr_back_idle", bus.busy, 0);
        check("wr_beat_count", wr_cnt - wr_base, int'(len) + 1);
    endtask

    // mode 0: ready held high; 1: ready 1,0,0 repeating; 2: random ready
    task automatic do_read(input logic [AW-1:0] a0, input logic [7:0] len, input int mode, input bit chk_lat);
        logic [AW-1:0] a = a0;
        int cyc = 0;
        int n   = 0;
        for (int i = 0; i <= int'(len); i++) begin
            ra.push_back(a);
            rq.push_back('{d: ref_mem[a], last: (i == int'(len))});
            a = (int'(a) == DEPTH - 1) ? '0 : a + 1'b1;
        end
        bus.rdata_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        cmd(1'b0, a0, len, 4'h0);
        if (chk_lat) begin
            check("lat_first_cycle_invalid", bus.rdata_valid, 0);
            for (int k = 0; k <= int'(len); k++) begin
                @(posedge clk); #1;
                check("stream_valid", bus.rdata_valid, 1);
            end
        end
        while ((rq.size() != 0 || bus.busy) && n < 1000) begin
            cyc++;
            if (mode == 1) bus.rdata_ready = ((cyc % 3) == 0);
            if (mode == 2) bus.rdata_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        check("rd_done_busy", bus.busy, 0);
        check("rd_left", rq.size(), 0);
        bus.rdata_ready = 1'b0;
    endtask

    initial begin
        int n;
        rst_n           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_len     = '0;
        bus.req_byte_en = '0;
        bus.wdata_valid = 1'b0;
        bus.wdata       = '0;
        bus.rdata_ready = 1'b0;
        #2 rst_n = 1'b0;

        // Outputs held quiet in reset, then ready on release
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_wdata_ready", bus.wdata_ready, 0);
        check("rst_rdata_valid", bus.rdata_valid, 0);
        check("rst_rdata_last", bus.rdata_last, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_wr_en", bus.mem_wr_en, 0);
        check("rst_mem_rd_en", bus.mem_rd_en, 0);
        rst_n = 1'b1;
        #1 check("rel_req_ready", bus.req_ready, 1);
        @(posedge clk); #1;

        // Basic write and back-to-back readback
        do_write(10'h010, 8'd3, 4'hF, 32'h1111_1111, 32'h1111_1111);
        do_read(10'h010, 8'd3, 0, 1'b1);

        // Throttled consumer
        do_write(10'h100, 8'd7, 4'hF, 32'hA000_0000, 32'h0101_0101);
        do_read(10'h100, 8'd7, 1, 1'b0);
        do_read(10'h100, 8'd7, 2, 1'b0);

        // Address wrap at the top of the array
        do_write(10'(DEPTH - 2), 8'd3, 4'hF, 32'h5000_0001, 32'h0000_0010);
        do_read(10'(DEPTH - 2), 8'd3, 0, 1'b1);

        // Partial byte-lane write
        do_write(10'h200, 8'd0, 4'hF, 32'h1122_3344, 32'h0);
        do_write(10'h200, 8'd0, 4'b0101, 32'hAABB_CCDD, 32'h0);
        check("be_model", ref_mem[10'h200], 32'h11BB_33DD);
        do_read(10'h200, 8'd0, 0, 1'b0);

        // Reset in the middle of a read burst
        for (int i = 0; i < 8; i++) begin
            ra.push_back(10'(10'h100 + i));
            rq.push_back('{d: ref_mem[10'h100 + i], last: (i == 7)});
        end
        bus.rdata_ready = 1'b1;
        n = pop_cnt;
        cmd(1'b0, 10'h100, 8'd7, 4'h0);
        begin
            int k = 0;
            while (pop_cnt < n + 2 && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
        end
        check("mid_reset_reached_beat2", pop_cnt - n, 2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdata_valid", bus.rdata_valid, 0);
        check("mid_rst_mem_rd_en", bus.mem_rd_en, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_req_ready", bus.req_ready, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check("mid_rel_req_ready", bus.req_ready, 1);
        bus.rdata_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_read(10'h100, 8'd7, 0, 1'b1);

        check("final_wq_empty", wq.size(), 0);
        check("final_rq_empty", rq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/sram_burst_ctrl.md
SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

Interface
REQ-001 SHALL have parameter BYTES, default 4, bytes per SRAM word (data width BYTES*8).
REQ-002 SHALL have parameter DEPTH, default 1024, SRAM words; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  in  1  burst command valid.
REQ-006 SHALL have port req_ready  out  1  command accepted when req_valid && req_ready.
REQ-007 SHALL have port req_write  in  1  1 = write burst, 0 = read burst.
REQ-008 SHALL have port req_addr  in  AW  first word address.
REQ-009 SHALL have port req_len  in  8  beats minus one (1..256 beats).
REQ-010 SHALL have port req_byte_en  in  BYTES  byte lanes applied to every write beat.
REQ-011 SHALL have ports wdata_valid in 1, wdata_ready out 1, wdata in BYTES*8: write beat stream.
REQ-012 SHALL have ports rdata_valid out 1, rdata_ready in 1, rdata out BYTES*8, rdata_last out 1: read beat stream.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have ports mem_wr_en out 1, mem_rd_en out 1, mem_address out AW, mem_data_in out BYTES*8, mem_byte_en out BYTES: SRAM command side.
REQ-015 SHALL have port mem_data_out  in  BYTES*8  SRAM read data, valid exactly one cycle after mem_rd_en.

Function
REQ-016 SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-017 IDLE: req_ready=1; on handshake latch addr, len, byte_en; go WRITE if req_write else READ; req_ready=0 in all other states.
REQ-018 WRITE: wdata_ready=1; each wdata handshake drives mem_wr_en=1, mem_address=current addr, mem_data_in=wdata, mem_byte_en=latched byte_en in that same cycle (combinational pass-through).
REQ-019 WRITE: after beat len+1 is accepted return to IDLE next cycle; wdata_ready=0 outside WRITE.
REQ-020 READ: assert mem_rd_en only when (fifo count + reads in flight) < 2; at most one read in flight.
REQ-021 Data from mem_data_out SHALL be pushed into a 2-entry response FIFO the cycle after mem_rd_en; rdata/rdata_valid come from FIFO head.
REQ-022 After issuing the final read go DRAIN; DRAIN returns to IDLE when FIFO is empty and nothing is in flight.
REQ-023 rdata_last SHALL be 1 exactly on the beat whose index equals len.
REQ-024 Address SHALL increment by 1 per issued beat and wrap DEPTH-1 -> 0.
REQ-025 mem_wr_en and mem_rd_en SHALL never be high in the same cycle.
REQ-026 Simultaneous FIFO push and pop SHALL keep count unchanged with order preserved; no beat lost or duplicated under any rdata_ready pattern.
REQ-027 Zero-beat-gap throughput: with rdata_ready held 1, one read beat per cycle after 1-cycle startup latency (first rdata_valid 2 cycles after command handshake).
REQ-028 mem_address, mem_data_in, mem_byte_en are don't-care when both enables are 0.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, FIFO empty, in-flight cleared, beat counter 0, address 0.
REQ-030 During reset outputs SHALL be: req_ready=0, wdata_ready=0, rdata_valid=0, rdata_last=0, busy=0, mem_wr_en=0, mem_rd_en=0; req_ready=1 first cycle after release.
REQ-031 Reset mid-burst SHALL abandon the burst without further SRAM accesses; SRAM contents already written are retained.

Verification
REQ-032 Write burst addr=0x010, len=3, byte_en=4'hF, wdata 0x11111111..0x44444444 back-to-back -> mem_wr_en 4 cycles, addresses 0x010..0x013, then IDLE.
REQ-033 Read same range, rdata_ready=1 -> rdata 0x11111111..0x44444444 on 4 consecutive cycles, rdata_last only on 0x44444444.
REQ-034 Read len=7 with rdata_ready toggling 1,0,0,1,... -> all 8 beats in order, mem_rd_en never issued with FIFO+in-flight = 2.
REQ-035 Write addr=DEPTH-2, len=3 -> addresses DEPTH-2, DEPTH-1, 0, 1.
REQ-036 Write byte_en=4'b0101 data 0xAABBCCDD over 0x11223344 -> readback 0x11BB33DD.
REQ-037 Assert rst_n=0 during beat 2 of a len=7 read -> rdata_valid and mem_rd_en drop immediately; after release req_ready=1, new read returns correct data.
